// File: rtl/harvard_bus_pkg.sv
// rtl/harvard_bus_pkg.sv - shared types and helpers for the Harvard-to-shared-bus bridge
package harvard_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        COMMIT,
        HALT
    } bridge_state_t;

    localparam int MAX_ADDR_W = 64;

    // Clears the byte-offset bits so the bus always sees a word address.
    function automatic logic [MAX_ADDR_W-1:0] word_align(
        input logic [MAX_ADDR_W-1:0] addr,
        input int unsigned           lsb_bits
    );
        return addr & ~((MAX_ADDR_W'(1) << lsb_bits) - MAX_ADDR_W'(1));
    endfunction

endpackage

// File: rtl/harvard_bus_bridge_if.sv
// rtl/harvard_bus_bridge_if.sv - Avalon-style shared memory port with waitrequest
interface harvard_bus_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );

endinterface

// File: rtl/harvard_bus_bridge.sv
// rtl/harvard_bus_bridge.sv - serialises a Harvard core's fetch and data ports onto one bus
module harvard_bus_bridge
    import harvard_bus_pkg::*;
#(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    input  logic              core_active,
    input  logic              instr_read,
    input  logic [ADDR_W-1:0] instr_address,
    output logic [DATA_W-1:0] instr_readdata,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [ADDR_W-1:0] data_address,
    input  logic [DATA_W-1:0] data_writedata,
    input  logic [BE_W-1:0]   byte_enable,
    output logic [DATA_W-1:0] data_readdata,
    output logic              core_clk_enable,
    output logic              proto_err,
    harvard_bus_bridge_if.master bus
);

    localparam int unsigned ALIGN_BITS = $clog2(BE_W);

    bridge_state_t     state;
    logic [DATA_W-1:0] instr_buf;
    logic [DATA_W-1:0] data_buf;
    logic              perr;
    logic              has_data;
    logic              data_done;

    // The core holds instr_read high whenever it runs, so every sequence fetches.
    logic unused_instr_read;
    assign unused_instr_read = instr_read;

    assign has_data  = data_read | data_write;
    assign data_done = !has_data || !bus.waitrequest;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            instr_buf <= '0;
            data_buf  <= '0;
            perr      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!core_active)   state <= HALT;
                    else if (clk_enable) state <= FETCH;
                end
                FETCH: begin
                    if (!bus.waitrequest) begin
                        instr_buf <= bus.readdata;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    if (data_read && data_write) perr <= 1'b1;
                    if (data_done) begin
                        // A conflicting read+write performs only the write.
                        if (data_read && !data_write) data_buf <= bus.readdata;
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (clk_enable) state <= core_active ? FETCH : HALT;
                end
                default: state <= HALT;
            endcase
        end
    end

    // Strobes derive from the async-reset state, so reset drops them without a clock.
    always_comb begin
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;
        bus.byteenable = '0;
        case (state)
            FETCH: begin
                bus.read       = 1'b1;
                bus.address    = ADDR_W'(word_align(MAX_ADDR_W'(instr_address), ALIGN_BITS));
                bus.byteenable = '1;
            end
            EXEC: begin
                if (data_write) begin
                    bus.write      = 1'b1;
                    bus.address    = ADDR_W'(word_align(MAX_ADDR_W'(data_address), ALIGN_BITS));
                    bus.writedata  = data_writedata;
                    bus.byteenable = byte_enable;
                end else if (data_read) begin
                    bus.read       = 1'b1;
                    bus.address    = ADDR_W'(word_align(MAX_ADDR_W'(data_address), ALIGN_BITS));
                    bus.byteenable = byte_enable;
                end
            end
            default: ;
        endcase
    end

    assign core_clk_enable = (state == COMMIT) && clk_enable;
    assign instr_readdata  = instr_buf;
    assign data_readdata   = data_buf;
    assign proto_err       = perr;

endmodule
